// File: rtl/bel_fft_mem_responder_if.sv
// -----------------------------------------------------------------------------
// bel_fft_mem_responder_if
//   Avalon-MM bus between the belfft master port (m_*) and the memory
//   responder. Clock and reset are not part of the bundle; they stay plain
//   ports on the modules that use it.
//
//   m_address        master -> slave  AWIDTH  byte address
//   m_writedata      master -> slave  DWIDTH  write data
//   m_read           master -> slave  1       read request
//   m_write          master -> slave  1       write request
//   m_waitrequest    slave -> master  1       stall, accepted on edge where low
//   m_readdata       slave -> master  DWIDTH  read data
//   m_readdatavalid  slave -> master  1       read data qualifier
// -----------------------------------------------------------------------------
interface bel_fft_mem_responder_if #(
   parameter int AWIDTH = 32,
   parameter int DWIDTH = 32
) ();
   logic [AWIDTH-1:0] m_address;
   logic [DWIDTH-1:0] m_writedata;
   logic              m_read;
   logic              m_write;
   logic              m_waitrequest;
   logic [DWIDTH-1:0] m_readdata;
   logic              m_readdatavalid;

   modport master (
      output m_address, m_writedata, m_read, m_write,
      input  m_waitrequest, m_readdata, m_readdatavalid
   );

   modport slave (
      input  m_address, m_writedata, m_read, m_write,
      output m_waitrequest, m_readdata, m_readdatavalid
   );
endinterface

// File: rtl/bel_fft_mem_responder.sv
// -----------------------------------------------------------------------------
// bel_fft_mem_responder
//   Avalon-MM slave memory sitting on the belfft master port. Two windows
//   (source / destination) of 2**RAM_AWIDTH words each, fixed wait-state
//   insertion before every access and fully pipelined fixed-latency reads.
//   A side-band load/dump port lets the host preload source data and read
//   results back without going through the bus.
//
//   clk_i            in   clock, rising edge
//   rst_i            in   synchronous reset, active high
//   m                     slave side of bel_fft_mem_responder_if
//   ld_we            in   side-band write strobe
//   ld_sel           in   side-band window, 0 = source, 1 = destination
//   ld_addr          in   side-band word index
//   ld_data          in   side-band write data
//   rd_data          out  side-band read data, registered from ld_sel/ld_addr
//   err_o            out  sticky protocol/decode error
// -----------------------------------------------------------------------------
module bel_fft_mem_responder #(
   parameter int         DWIDTH       = 32,
   parameter int         AWIDTH       = 32,
   parameter int         RAM_AWIDTH   = 6,
   parameter int         WAIT_STATES  = 0,
   parameter int         READ_LATENCY = 2,
   parameter logic [1:0] SRC_SEL      = 2'b01,
   parameter logic [1:0] DST_SEL      = 2'b10
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   bel_fft_mem_responder_if.slave    m,
   input  logic                      ld_we,
   input  logic                      ld_sel,
   input  logic [RAM_AWIDTH-1:0]     ld_addr,
   input  logic [DWIDTH-1:0]         ld_data,
   output logic [DWIDTH-1:0]         rd_data,
   output logic                      err_o
);

   localparam int                DEPTH         = 1 << RAM_AWIDTH;
   localparam logic [DWIDTH-1:0] UNMAPPED_WORD = DWIDTH'(32'hDEAD_BEEF);
   localparam logic [3:0]        WS            = 4'(WAIT_STATES);

   typedef enum logic {ST_IDLE, ST_STALL} state_t;

   // ---------------------------------------------------------------- decode
   logic [1:0]            w_win;
   logic [RAM_AWIDTH-1:0] w_idx;
   logic                  w_src_hit;
   logic                  w_dst_hit;
   logic                  w_unused_addr;

   assign w_win     = m.m_address[RAM_AWIDTH+3:RAM_AWIDTH+2];
   assign w_idx     = m.m_address[RAM_AWIDTH+1:2];
   assign w_src_hit = (w_win == SRC_SEL);
   assign w_dst_hit = (w_win == DST_SEL);
   // byte-lane bits and address bits above the window code are don't-care
   assign w_unused_addr = ^{m.m_address[AWIDTH-1:RAM_AWIDTH+4], m.m_address[1:0]};

   // ------------------------------------------------------- wait-state FSM
   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_wcnt;
   logic       w_req;
   logic       w_stall;
   logic       w_accept;
   logic       w_waitrequest;

   assign w_req    = m.m_read | m.m_write;
   assign w_stall  = (r_wcnt != WS);
   assign w_accept = w_req & ~w_stall;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
         r_wcnt  <= '0;
      end else begin
         r_state <= w_state_nxt;
         // counts only while stalled; acceptance or a dropped request clears it
         r_wcnt  <= (w_state_nxt == ST_STALL) ? r_wcnt + 4'd1 : 4'd0;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (w_req & w_stall)    w_state_nxt = ST_STALL;
         ST_STALL: if (!(w_req & w_stall)) w_state_nxt = ST_IDLE;
         default:                          w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_waitrequest = w_req & w_stall;
   end

   assign m.m_waitrequest = w_waitrequest;

   // --------------------------------------------------------- access decode
   logic w_wr_acc;
   logic w_rd_acc;
   logic w_err_evt;

   // a simultaneous read+write is serviced as a write only
   assign w_wr_acc  = w_accept & m.m_write;
   assign w_rd_acc  = w_accept & m.m_read & ~m.m_write;
   assign w_err_evt = w_accept & ((m.m_read & m.m_write) | ~(w_src_hit | w_dst_hit));

   // ---------------------------------------------------------------- memory
   logic [DWIDTH-1:0] r_src_mem [DEPTH];
   logic [DWIDTH-1:0] r_dst_mem [DEPTH];

   // No reset: contents survive rst_i. The master write is placed after the
   // side-band write so it wins when both hit the same word on one edge.
   always_ff @(posedge clk_i) begin
      if (ld_we & ~ld_sel)        r_src_mem[ld_addr] <= ld_data;
      if (ld_we &  ld_sel)        r_dst_mem[ld_addr] <= ld_data;
      if (w_wr_acc & w_src_hit)   r_src_mem[w_idx]   <= m.m_writedata;
      if (w_wr_acc & w_dst_hit)   r_dst_mem[w_idx]   <= m.m_writedata;
   end

   logic [DWIDTH-1:0] w_rd_word;

   always_comb begin
      w_rd_word = UNMAPPED_WORD;
      if (w_src_hit)      w_rd_word = r_src_mem[w_idx];
      else if (w_dst_hit) w_rd_word = r_dst_mem[w_idx];
   end

   // ---------------------------------------------------------- read pipeline
   // Stage 1 is loaded on the acceptance edge, so stage READ_LATENCY is
   // presented exactly READ_LATENCY cycles after the request cycle.
   logic [READ_LATENCY:1]             r_vld_pipe;
   logic [READ_LATENCY:1][DWIDTH-1:0] r_dat_pipe;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_vld_pipe <= '0;
         r_dat_pipe <= '0;
      end else begin
         r_vld_pipe[1] <= w_rd_acc;
         if (w_rd_acc) r_dat_pipe[1] <= w_rd_word;
         for (int i = 2; i <= READ_LATENCY; i++) begin
            r_vld_pipe[i] <= r_vld_pipe[i-1];
            r_dat_pipe[i] <= r_dat_pipe[i-1];
         end
      end
   end

   // Masking with rst_i keeps a read that would surface during the reset
   // cycle from escaping; the pipeline itself is flushed on the reset edge.
   assign m.m_readdatavalid = r_vld_pipe[READ_LATENCY] & ~rst_i;
   assign m.m_readdata      = r_dat_pipe[READ_LATENCY];

   // ----------------------------------------------------- side-band / error
   logic [DWIDTH-1:0] r_rd_data;
   logic              r_err;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rd_data <= '0;
         r_err     <= 1'b0;
      end else begin
         // old contents on a same-edge write; new data appears one cycle later
         r_rd_data <= ld_sel ? r_dst_mem[ld_addr] : r_src_mem[ld_addr];
         if (w_err_evt) r_err <= 1'b1;
      end
   end

   assign rd_data = r_rd_data;
   assign err_o   = r_err;

endmodule
